// File: rtl/alu_writeback.sv
// ============================================================================
//  Module   : alu_writeback
//  Purpose  : ALU writeback stage. Buffers Y1/Y2 result pairs in a FIFO and
//             retires them through a single register-file write port.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_writeback #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int DEPTH  = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,

  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DATA_W-1:0]            in_y1,
  input  logic [DATA_W-1:0]            in_y2,
  input  logic [REG_AW-1:0]            in_dst1,
  input  logic [REG_AW-1:0]            in_dst2,
  input  logic [1:0]                   in_mask,

  output logic                         wr_en,
  input  logic                         wr_ready,
  output logic [REG_AW-1:0]            wr_addr,
  output logic [DATA_W-1:0]            wr_data,

  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         busy
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0] C_FULL = CNT_W'(DEPTH);

  typedef enum logic [0:0] {
    PH_FIRST  = 1'b0,
    PH_SECOND = 1'b1
  } phase_t;

  logic [DATA_W-1:0] r_y1_mem   [DEPTH];
  logic [DATA_W-1:0] r_y2_mem   [DEPTH];
  logic [REG_AW-1:0] r_dst1_mem [DEPTH];
  logic [REG_AW-1:0] r_dst2_mem [DEPTH];
  logic [1:0]        r_mask_mem [DEPTH];

  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  phase_t            r_phase;
  phase_t            w_phase_nxt;

  logic              w_push;
  logic              w_pop;
  logic              w_empty;

  logic [DATA_W-1:0] w_head_y1;
  logic [DATA_W-1:0] w_head_y2;
  logic [REG_AW-1:0] w_head_dst1;
  logic [REG_AW-1:0] w_head_dst2;
  logic [1:0]        w_head_mask;

  // Full-only readiness: a pop in the same cycle never opens a slot early.
  assign in_ready = (r_count < C_FULL);
  assign w_push   = in_valid && in_ready;
  assign w_empty  = (r_count == '0);
  assign count    = r_count;
  assign busy     = !w_empty;

  assign w_head_y1   = r_y1_mem[r_rd_ptr];
  assign w_head_y2   = r_y2_mem[r_rd_ptr];
  assign w_head_dst1 = r_dst1_mem[r_rd_ptr];
  assign w_head_dst2 = r_dst2_mem[r_rd_ptr];
  assign w_head_mask = r_mask_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_y1_mem[r_wr_ptr]   <= in_y1;
      r_y2_mem[r_wr_ptr]   <= in_y2;
      r_dst1_mem[r_wr_ptr] <= in_dst1;
      r_dst2_mem[r_wr_ptr] <= in_dst2;
      r_mask_mem[r_wr_ptr] <= in_mask;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_phase  <= PH_FIRST;
    end else begin
      r_phase <= w_phase_nxt;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Head sequencer: Y1 always precedes Y2; an all-zero mask still spends one cycle.
  always_comb begin
    wr_en       = 1'b0;
    wr_addr     = '0;
    wr_data     = '0;
    w_pop       = 1'b0;
    w_phase_nxt = r_phase;
    if (!w_empty) begin
      unique case (r_phase)
        PH_FIRST: begin
          if (w_head_mask[0]) begin
            wr_en   = 1'b1;
            wr_addr = w_head_dst1;
            wr_data = w_head_y1;
            if (wr_ready) begin
              if (w_head_mask[1]) begin
                w_phase_nxt = PH_SECOND;
              end else begin
                w_pop = 1'b1;
              end
            end
          end else if (w_head_mask[1]) begin
            wr_en   = 1'b1;
            wr_addr = w_head_dst2;
            wr_data = w_head_y2;
            w_pop   = wr_ready;
          end else begin
            w_pop = 1'b1;
          end
        end
        PH_SECOND: begin
          wr_en   = 1'b1;
          wr_addr = w_head_dst2;
          wr_data = w_head_y2;
          if (wr_ready) begin
            w_pop       = 1'b1;
            w_phase_nxt = PH_FIRST;
          end
        end
        default: w_phase_nxt = PH_FIRST;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_writeback.sv
// ============================================================================
//  Module   : tb_alu_writeback
//  Purpose  : Directed and randomised self-checking bench for alu_writeback.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_alu_writeback;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = $clog2(DEPTH+1);

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_y1;
  logic [DATA_W-1:0] in_y2;
  logic [REG_AW-1:0] in_dst1;
  logic [REG_AW-1:0] in_dst2;
  logic [1:0]        in_mask;
  logic              wr_en;
  logic              wr_ready;
  logic [REG_AW-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [CNT_W-1:0]  count;
  logic              busy;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [REG_AW-1:0] a;
    logic [DATA_W-1:0] d;
  } wr_t;

  wr_t got[$];
  wr_t exp_q[$];

  always #5 clk = ~clk;

  alu_writeback #(
    .DATA_W (DATA_W),
    .REG_AW (REG_AW),
    .DEPTH  (DEPTH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_y1    (in_y1),
    .in_y2    (in_y2),
    .in_dst1  (in_dst1),
    .in_dst2  (in_dst2),
    .in_mask  (in_mask),
    .wr_en    (wr_en),
    .wr_ready (wr_ready),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .count    (count),
    .busy     (busy)
  );

  // Granted writes are logged mid-cycle, where wr_ready is stable for the next edge.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && wr_en === 1'b1 && wr_ready === 1'b1)
      got.push_back({wr_addr, wr_data});
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_entry(input logic [DATA_W-1:0] y1, input logic [DATA_W-1:0] y2,
                            input logic [REG_AW-1:0] d1, input logic [REG_AW-1:0] d2,
                            input logic [1:0] m);
    logic acc;
    logic done;
    done     = 1'b0;
    in_y1    = y1;
    in_y2    = y2;
    in_dst1  = d1;
    in_dst2  = d2;
    in_mask  = m;
    in_valid = 1'b1;
    for (int i = 0; i < 64 && !done; i++) begin
      @(negedge clk);
      acc = in_ready;
      step();
      if (acc) done = 1'b1;
    end
    in_valid = 1'b0;
    if (!done) begin
      total++; bad++;
      $display("FAIL push_timeout got=not_accepted want=accepted");
    end
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    wr_ready = 1'b0;
    in_y1 = '0; in_y2 = '0; in_dst1 = '0; in_dst2 = '0; in_mask = '0;
    repeat (3) step();
    @(negedge clk);
    total++; if (wr_en !== 1'b0)   begin bad++; $display("FAIL reset_wr_en got=%0b want=0", wr_en); end
    total++; if (busy !== 1'b0)    begin bad++; $display("FAIL reset_busy got=%0b want=0", busy); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%0b want=1", in_ready); end
    total++; if (count !== 3'd0)   begin bad++; $display("FAIL reset_count got=%0d want=0", count); end
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_two_writes();
    wr_ready = 1'b1;
    push_entry(32'd4, 32'd4, 5'd3, 5'd7, 2'b11);
    @(negedge clk);
    total++; if (wr_en !== 1'b1)    begin bad++; $display("FAIL two_w1_en got=%0b want=1", wr_en); end
    total++; if (wr_addr !== 5'd3)  begin bad++; $display("FAIL two_w1_addr got=%0d want=3", wr_addr); end
    total++; if (wr_data !== 32'd4) begin bad++; $display("FAIL two_w1_data got=%0h want=4", wr_data); end
    step();
    @(negedge clk);
    total++; if (wr_en !== 1'b1)    begin bad++; $display("FAIL two_w2_en got=%0b want=1", wr_en); end
    total++; if (wr_addr !== 5'd7)  begin bad++; $display("FAIL two_w2_addr got=%0d want=7", wr_addr); end
    total++; if (wr_data !== 32'd4) begin bad++; $display("FAIL two_w2_data got=%0h want=4", wr_data); end
    step();
    @(negedge clk);
    total++; if (count !== 3'd0)  begin bad++; $display("FAIL two_count got=%0d want=0", count); end
    total++; if (busy !== 1'b0)   begin bad++; $display("FAIL two_busy got=%0b want=0", busy); end
    total++; if (wr_en !== 1'b0)  begin bad++; $display("FAIL two_idle_en got=%0b want=0", wr_en); end
    step();
  endtask

  task automatic test_wide();
    wr_t e0, e1;
    e0 = {5'd10, 32'hFFFF_FFFF};
    e1 = {5'd11, 32'hFFFF_FFFC};
    got.delete();
    wr_ready = 1'b1;
    push_entry(32'hFFFF_FFFF, 32'hFFFF_FFFC, 5'd10, 5'd11, 2'b11);
    for (int i = 0; i < 20 && got.size() < 2; i++) step();
    repeat (2) step();
    total++;
    if (got.size() != 2) begin
      bad++; $display("FAIL wide_count got=%0d want=2", got.size());
    end else begin
      total++; if (got[0] !== e0) begin bad++; $display("FAIL wide_first got=%0d/%0h want=10/ffffffff", got[0].a, got[0].d); end
      total++; if (got[1] !== e1) begin bad++; $display("FAIL wide_second got=%0d/%0h want=11/fffffffc", got[1].a, got[1].d); end
    end
  endtask

  task automatic test_masks();
    wr_t e0, e1;
    e0 = {5'd1, 32'hA1A1_0001};
    e1 = {5'd5, 32'hB2B2_0002};
    got.delete();
    wr_ready = 1'b1;
    push_entry(32'hA1A1_0001, 32'hA2A2_0001, 5'd1, 5'd2, 2'b01);
    push_entry(32'hB1B1_0002, 32'hB2B2_0002, 5'd4, 5'd5, 2'b10);
    push_entry(32'hC1C1_0003, 32'hC2C2_0003, 5'd8, 5'd9, 2'b00);
    @(negedge clk);
    total++; if (count !== 3'd1) begin bad++; $display("FAIL mask00_count got=%0d want=1", count); end
    total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL mask00_wr_en got=%0b want=0", wr_en); end
    step();
    @(negedge clk);
    total++; if (count !== 3'd0) begin bad++; $display("FAIL masks_drained got=%0d want=0", count); end
    repeat (3) step();
    total++;
    if (got.size() != 2) begin
      bad++; $display("FAIL masks_writes got=%0d want=2", got.size());
    end else begin
      total++; if (got[0] !== e0) begin bad++; $display("FAIL mask01_write got=%0d/%0h want=1/a1a10001", got[0].a, got[0].d); end
      total++; if (got[1] !== e1) begin bad++; $display("FAIL mask10_write got=%0d/%0h want=5/b2b20002", got[1].a, got[1].d); end
    end
  endtask

  task automatic test_full();
    wr_t e;
    got.delete();
    wr_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      push_entry(32'd100 + 32'(i), 32'd200 + 32'(i), 5'(2*i), 5'(2*i+1), 2'b11);
    push_entry_hold: begin
      in_y1 = 32'd999; in_y2 = 32'd998; in_dst1 = 5'd30; in_dst2 = 5'd31; in_mask = 2'b11;
      in_valid = 1'b1;
    end
    @(negedge clk);
    total++; if (count !== 3'd4)     begin bad++; $display("FAIL full_count got=%0d want=4", count); end
    total++; if (in_ready !== 1'b0)  begin bad++; $display("FAIL full_in_ready got=%0b want=0", in_ready); end
    for (int k = 0; k < 3; k++) begin
      total++;
      if (wr_en !== 1'b1 || wr_addr !== 5'd0 || wr_data !== 32'd100) begin
        bad++; $display("FAIL stall_stable got=%0b/%0d/%0d want=1/0/100", wr_en, wr_addr, wr_data);
      end
      total++; if (count !== 3'd4) begin bad++; $display("FAIL stall_count got=%0d want=4", count); end
      if (k < 2) begin
        step();
        @(negedge clk);
      end
    end
    step();
    in_valid = 1'b0;
    wr_ready = 1'b1;
    @(negedge clk);
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL release_ready0 got=%0b want=0", in_ready); end
    step();
    @(negedge clk);
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL release_ready1 got=%0b want=0", in_ready); end
    step();
    @(negedge clk);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL release_ready2 got=%0b want=1", in_ready); end
    total++; if (count !== 3'd3)    begin bad++; $display("FAIL release_count got=%0d want=3", count); end
    for (int i = 0; i < 30 && got.size() < 8; i++) step();
    repeat (3) step();
    total++;
    if (got.size() != 8) begin
      bad++; $display("FAIL full_writes got=%0d want=8", got.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        e = (i % 2 == 0) ? {5'(i), 32'd100 + 32'(i/2)} : {5'(i), 32'd200 + 32'(i/2)};
        total++;
        if (got[i] !== e) begin
          bad++; $display("FAIL full_order[%0d] got=%0d/%0d want=%0d/%0d", i, got[i].a, got[i].d, e.a, e.d);
        end
      end
    end
    total++; if (count !== 3'd0) begin bad++; $display("FAIL full_drained got=%0d want=0", count); end
  endtask

  task automatic test_reset_mid();
    wr_t e0;
    e0 = {5'd20, 32'h0000_1111};
    got.delete();
    wr_ready = 1'b1;
    push_entry(32'h0000_1111, 32'h0000_2222, 5'd20, 5'd21, 2'b11);
    @(negedge clk);
    total++; if (wr_addr !== 5'd20) begin bad++; $display("FAIL rmid_first got=%0d want=20", wr_addr); end
    step();
    rst_n    = 1'b0;
    wr_ready = 1'b0;
    @(negedge clk);
    total++; if (wr_addr !== 5'd21) begin bad++; $display("FAIL rmid_second got=%0d want=21", wr_addr); end
    step();
    rst_n    = 1'b1;
    wr_ready = 1'b1;
    @(negedge clk);
    total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL rmid_wr_en got=%0b want=0", wr_en); end
    total++; if (count !== 3'd0) begin bad++; $display("FAIL rmid_count got=%0d want=0", count); end
    repeat (4) step();
    total++;
    if (got.size() != 1 || got[0] !== e0) begin
      bad++; $display("FAIL rmid_writes got=%0d want=1 (addr 20 only)", got.size());
    end
  endtask

  task automatic test_back_to_back();
    logic              hold;
    logic              acc;
    logic [REG_AW-1:0] p_addr;
    logic [DATA_W-1:0] p_data;
    int                n;
    got.delete();
    exp_q.delete();
    hold     = 1'b0;
    in_valid = 1'b0;
    for (int cyc = 0; cyc < 1000; cyc++) begin
      wr_ready = 1'($urandom_range(0, 1));
      if (!in_valid && $urandom_range(0, 3) != 0) begin
        in_y1    = $urandom;
        in_y2    = $urandom;
        in_dst1  = 5'($urandom_range(0, 31));
        in_dst2  = 5'($urandom_range(0, 31));
        in_mask  = 2'($urandom_range(0, 3));
        in_valid = 1'b1;
      end
      @(negedge clk);
      if (hold) begin
        total++;
        if (wr_en !== 1'b1 || wr_addr !== p_addr || wr_data !== p_data) begin
          bad++; $display("FAIL rand_stable cyc=%0d got=%0b/%0d/%0h want=1/%0d/%0h",
                          cyc, wr_en, wr_addr, wr_data, p_addr, p_data);
        end
      end
      hold   = wr_en && !wr_ready;
      p_addr = wr_addr;
      p_data = wr_data;
      acc    = in_valid && in_ready;
      step();
      if (acc) begin
        if (in_mask[0]) exp_q.push_back({in_dst1, in_y1});
        if (in_mask[1]) exp_q.push_back({in_dst2, in_y2});
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    wr_ready = 1'b1;
    repeat (40) step();
    total++;
    if (got.size() != exp_q.size()) begin
      bad++; $display("FAIL rand_write_count got=%0d want=%0d", got.size(), exp_q.size());
    end
    n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      total++;
      if (got[i] !== exp_q[i]) begin
        bad++; $display("FAIL rand_write[%0d] got=%0d/%0h want=%0d/%0h",
                        i, got[i].a, got[i].d, exp_q[i].a, exp_q[i].d);
      end
    end
    total++; if (count !== 3'd0) begin bad++; $display("FAIL rand_drained got=%0d want=0", count); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_two_writes();
    test_wide();
    test_masks();
    test_full();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
